// File: rtl/uart_pkg.sv
// uart_pkg: shared state types, framing constants and divisor helper for the
// UART loopback core. Optional feature: define PARITY_EN for 8E1 framing
// (even parity bit inserted after data bit 7).
package uart_pkg;

  localparam int DATA_BITS        = 8;
  localparam int BIT_IDX_W        = $clog2(DATA_BITS);
  localparam int SAMPLES_PER_BIT  = 16;
  localparam int SAMPLE_CNT_W     = $clog2(SAMPLES_PER_BIT);
  localparam int HALF_BIT_SAMPLE  = SAMPLES_PER_BIT / 2;
  localparam int DEFAULT_CLK_FREQ = 100_000_000;
  localparam int DEFAULT_BAUD     = 115_200;

  // Rounded integer division used to derive both baud divisors.
  function automatic int round_div(input int num, input int den);
    return (num + den / 2) / den;
  endfunction

`ifdef PARITY_EN
  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_t;
`else
  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;
`endif

endpackage

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling receiver with a 2-flop line synchroniser and the
// sticky rdy / data_out handshake. Honours PARITY_EN (even parity check).
module uart_rx
  import uart_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_tick,
  input  logic                 rx_line,
  input  logic                 rdy_clr,
  output logic                 rdy,
  output logic [DATA_BITS-1:0] data_out
);

  logic                    rx_meta;
  logic                    rx_sync;
  rx_state_t               rx_state, rx_state_next;
  logic [SAMPLE_CNT_W-1:0] sample_cnt, sample_cnt_next;
  logic [BIT_IDX_W-1:0]    bit_idx, bit_idx_next;
  logic [DATA_BITS-1:0]    rx_shift, rx_shift_next;
  logic                    byte_ok;
`ifdef PARITY_EN
  logic                    parity_bit, parity_bit_next;
`endif

  // Two-flop synchroniser; resets to the idle (high) line level.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_line;
      rx_sync <= rx_meta;
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state   <= RX_IDLE;
      sample_cnt <= '0;
      bit_idx    <= '0;
      rx_shift   <= '0;
`ifdef PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      rx_state   <= rx_state_next;
      sample_cnt <= sample_cnt_next;
      bit_idx    <= bit_idx_next;
      rx_shift   <= rx_shift_next;
`ifdef PARITY_EN
      parity_bit <= parity_bit_next;
`endif
    end
  end

  // Receiver next-state logic: advances only on oversampling ticks.
  // NOTE: every signal assigned here gets a default first so no path infers a latch.
  always_comb begin
    rx_state_next   = rx_state;
    sample_cnt_next = sample_cnt;
    bit_idx_next    = bit_idx;
    rx_shift_next   = rx_shift;
    byte_ok         = 1'b0;
`ifdef PARITY_EN
    parity_bit_next = parity_bit;
`endif
    if (rx_tick) begin
      case (rx_state)
        RX_IDLE: begin
          if (!rx_sync) begin
            rx_state_next   = RX_START;
            sample_cnt_next = '0;
          end
        end
        RX_START: begin
          // Re-check the start bit at its midpoint to reject glitches.
          if (sample_cnt == SAMPLE_CNT_W'(HALF_BIT_SAMPLE - 1)) begin
            sample_cnt_next = '0;
            if (!rx_sync) begin
              rx_state_next = RX_DATA;
              bit_idx_next  = '0;
            end else begin
              rx_state_next = RX_IDLE;
            end
          end else begin
            sample_cnt_next = sample_cnt + SAMPLE_CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (sample_cnt == SAMPLE_CNT_W'(SAMPLES_PER_BIT - 1)) begin
            sample_cnt_next = '0;
            rx_shift_next   = {rx_sync, rx_shift[DATA_BITS-1:1]};
            if (bit_idx == BIT_IDX_W'(DATA_BITS - 1)) begin
`ifdef PARITY_EN
              rx_state_next = RX_PARITY;
`else
              rx_state_next = RX_STOP;
`endif
            end else begin
              bit_idx_next = bit_idx + BIT_IDX_W'(1);
            end
          end else begin
            sample_cnt_next = sample_cnt + SAMPLE_CNT_W'(1);
          end
        end
`ifdef PARITY_EN
        RX_PARITY: begin
          if (sample_cnt == SAMPLE_CNT_W'(SAMPLES_PER_BIT - 1)) begin
            sample_cnt_next = '0;
            parity_bit_next = rx_sync;
            rx_state_next   = RX_STOP;
          end else begin
            sample_cnt_next = sample_cnt + SAMPLE_CNT_W'(1);
          end
        end
`endif
        RX_STOP: begin
          // A low stop bit (or bad parity) silently drops the byte.
          if (sample_cnt == SAMPLE_CNT_W'(SAMPLES_PER_BIT - 1)) begin
            sample_cnt_next = '0;
            rx_state_next   = RX_IDLE;
`ifdef PARITY_EN
            byte_ok = rx_sync && ((^rx_shift) == parity_bit);
`else
            byte_ok = rx_sync;
`endif
          end else begin
            sample_cnt_next = sample_cnt + SAMPLE_CNT_W'(1);
          end
        end
        default: rx_state_next = RX_IDLE;
      endcase
    end
  end

  // Sticky rdy flag; a completing byte wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy      <= 1'b0;
      data_out <= '0;
    end else if (byte_ok) begin
      rdy      <= 1'b1;
      data_out <= rx_shift;
    end else if (rdy_clr) begin
      rdy      <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_loopback_top.sv
// uart_loopback_top: baud generator and transmitter FSM whose serial line is
// looped internally into uart_rx. Define PARITY_EN for 8E1 framing.
module uart_loopback_top
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
  parameter int BAUD       = DEFAULT_BAUD,
  parameter int OVERSAMPLE = SAMPLES_PER_BIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy_clr,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 busy,
  output logic                 rdy,
  output logic [DATA_BITS-1:0] data_out
);

  localparam int TX_DIV = round_div(CLK_FREQ, BAUD);
  localparam int RX_DIV = round_div(CLK_FREQ, BAUD * OVERSAMPLE);
  localparam int TX_CW  = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;
  localparam int RX_CW  = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;

  logic [TX_CW-1:0]     tx_cnt;
  logic [RX_CW-1:0]     rx_cnt;
  logic                 tx_tick;
  logic                 rx_tick;

  tx_state_t            tx_state, tx_state_next;
  logic [BIT_IDX_W-1:0] tx_bit_idx, tx_bit_idx_next;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_next;
  logic                 tx_line, tx_line_next;
  logic                 tx_start_q;
  logic                 start_edge;

  assign tx_tick = (tx_cnt == TX_CW'(TX_DIV - 1));
  assign rx_tick = (rx_cnt == RX_CW'(RX_DIV - 1));

  // Free-running baud counters; each wrap emits a one-clock tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_cnt <= '0;
      rx_cnt <= '0;
    end else begin
      tx_cnt <= tx_tick ? '0 : tx_cnt + TX_CW'(1);
      rx_cnt <= rx_tick ? '0 : rx_cnt + RX_CW'(1);
    end
  end

  // Transmitter state, datapath, line register and tx_start edge detector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state   <= TX_IDLE;
      tx_bit_idx <= '0;
      tx_shift   <= '0;
      tx_line    <= 1'b1;
      tx_start_q <= 1'b0;
    end else begin
      tx_state   <= tx_state_next;
      tx_bit_idx <= tx_bit_idx_next;
      tx_shift   <= tx_shift_next;
      tx_line    <= tx_line_next;
      tx_start_q <= tx_start;
    end
  end

  // Only a fresh rising edge launches a frame; a held level does not.
  assign start_edge = tx_start & ~tx_start_q;

  // Transmitter next-state logic; the line level is registered from the next state.
  always_comb begin
    tx_state_next   = tx_state;
    tx_bit_idx_next = tx_bit_idx;
    tx_shift_next   = tx_shift;
    case (tx_state)
      TX_IDLE: begin
        if (start_edge) begin
          tx_shift_next = data_in;
          tx_state_next = TX_START;
        end
      end
      TX_START: begin
        if (tx_tick) begin
          tx_state_next   = TX_DATA;
          tx_bit_idx_next = '0;
        end
      end
      TX_DATA: begin
        if (tx_tick) begin
          if (tx_bit_idx == BIT_IDX_W'(DATA_BITS - 1)) begin
`ifdef PARITY_EN
            tx_state_next = TX_PARITY;
`else
            tx_state_next = TX_STOP;
`endif
          end else begin
            tx_bit_idx_next = tx_bit_idx + BIT_IDX_W'(1);
          end
        end
      end
`ifdef PARITY_EN
      TX_PARITY: begin
        if (tx_tick) tx_state_next = TX_STOP;
      end
`endif
      TX_STOP: begin
        if (tx_tick) tx_state_next = TX_IDLE;
      end
      default: tx_state_next = TX_IDLE;
    endcase

    case (tx_state_next)
      TX_START:  tx_line_next = 1'b0;
      TX_DATA:   tx_line_next = tx_shift_next[tx_bit_idx_next];
`ifdef PARITY_EN
      TX_PARITY: tx_line_next = ^tx_shift_next;
`endif
      default:   tx_line_next = 1'b1;
    endcase
  end

  assign busy = (tx_state != TX_IDLE);

  uart_rx u_rx (
    .clk      (clk),
    .rst      (rst),
    .rx_tick  (rx_tick),
    .rx_line  (tx_line),
    .rdy_clr  (rdy_clr),
    .rdy      (rdy),
    .data_out (data_out)
  );

endmodule

// File: tb/tb_uart_loopback_top.sv
// tb_uart_loopback_top: directed loopback bench using a scaled-down baud setup
// (160 clocks per bit, 10 clocks per oversampling tick).
module tb_uart_loopback_top;

  localparam int FRAME_BUDGET = 2500;
  localparam int HOLD_CLKS    = 3600;

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic       rdy_clr  = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] data_in  = 8'h00;
  logic       busy;
  logic       rdy;
  logic [7:0] data_out;

  int checks = 0;
  int errors = 0;

  uart_loopback_top #(
    .CLK_FREQ   (1_600_000),
    .BAUD       (10_000),
    .OVERSAMPLE (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy_clr  (rdy_clr),
    .tx_start (tx_start),
    .data_in  (data_in),
    .busy     (busy),
    .rdy      (rdy),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    data_in  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic wait_rdy(input string tag);
    int n = 0;
    while (rdy !== 1'b1 && n < FRAME_BUDGET) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rdy"}, 32'(rdy), 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic clear_rdy();
    @(negedge clk);
    rdy_clr = 1'b1;
    @(negedge clk);
    rdy_clr = 1'b0;
  endtask

  initial begin
    int   rises;
    logic prev_busy;
    logic rdy_seen;
    logic busy_seen;

    // Reset held for ten clocks.
    repeat (10) @(negedge clk);
    rst = 1'b1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rdy", 32'(rdy), 32'd0);
    check("reset_data", 32'(data_out), 32'h00);

    // Single byte; rdy must rise while the stop bit is still going out.
    send(8'h13);
    check("single_busy_set", 32'(busy), 32'd1);
    wait_rdy("single");
    check("single_data", 32'(data_out), 32'h13);
    check("single_busy_at_rdy", 32'(busy), 32'd1);
    wait_idle("single", 500);

    // Clear then resend.
    clear_rdy();
    check("clear_rdy", 32'(rdy), 32'd0);
    check("clear_keeps_data", 32'(data_out), 32'h13);
    send(8'h50);
    wait_rdy("resend");
    check("resend_data", 32'(data_out), 32'h50);
    wait_idle("resend", 500);

    // Boundary values; 8'hFF is sent with rdy still set and must overwrite.
    clear_rdy();
    send(8'h00);
    wait_rdy("zero");
    check("zero_data", 32'(data_out), 32'h00);
    wait_idle("zero", 500);
    send(8'hFF);
    wait_idle("ones", FRAME_BUDGET);
    repeat (5) @(negedge clk);
    check("ones_data", 32'(data_out), 32'hFF);
    check("ones_rdy", 32'(rdy), 32'd1);

    // A second edge during a frame is ignored.
    clear_rdy();
    send(8'h81);
    repeat (200) @(negedge clk);
    data_in  = 8'h7E;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    wait_rdy("ignored_edge");
    check("ignored_edge_data", 32'(data_out), 32'h81);
    wait_idle("ignored_edge", 500);
    repeat (20) @(negedge clk);
    check("ignored_edge_no_frame", 32'(busy), 32'd0);

    // tx_start held high across two frame times: exactly one frame.
    clear_rdy();
    @(negedge clk);
    data_in   = 8'h3C;
    tx_start  = 1'b1;
    rises     = 0;
    prev_busy = 1'b0;
    for (int i = 0; i < HOLD_CLKS; i++) begin
      @(negedge clk);
      if (busy && !prev_busy) rises++;
      prev_busy = busy;
    end
    tx_start = 1'b0;
    check("held_frame_count", 32'(rises), 32'd1);
    check("held_data", 32'(data_out), 32'h3C);
    check("held_rdy", 32'(rdy), 32'd1);

    // Reset in the middle of the data bits of 8'hA5.
    send(8'hA5);
    repeat (400) @(negedge clk);
    check("midframe_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("midframe_reset_busy", 32'(busy), 32'd0);
    check("midframe_reset_rdy", 32'(rdy), 32'd0);
    check("midframe_reset_data", 32'(data_out), 32'h00);
    repeat (20) @(negedge clk);
    rst       = 1'b1;
    rdy_seen  = 1'b0;
    busy_seen = 1'b0;
    for (int i = 0; i < HOLD_CLKS; i++) begin
      @(negedge clk);
      rdy_seen  = rdy_seen | rdy;
      busy_seen = busy_seen | busy;
    end
    check("post_reset_no_rdy", 32'(rdy_seen), 32'd0);
    check("post_reset_no_busy", 32'(busy_seen), 32'd0);
    check("post_reset_data", 32'(data_out), 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Run-length guard in case a wait loop never completes.
  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog expired after 60000 clocks");
    $fatal(1, "watchdog");
  end

endmodule
